// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// slave word addresses and the default expected ID/timestamp values.
package sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;
  localparam int unsigned SYSID_CNT_W  = 3;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [SYSID_DATA_W-1:0] SYSID_DEFAULT_TS = 32'd1476146582;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WT_ID,
    S_RD_TS,
    S_WT_TS,
    S_CHECK,
    S_DONE
  } sysid_state_t;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words,
// compares them with the expected build values and reports pass/fail.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID  = SYSID_DEFAULT_ID,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS  = SYSID_DEFAULT_TS,
  parameter int unsigned             READ_LATENCY = 0,
  parameter bit                      AUTO_START   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    address,
  output logic                    read,
  input  logic [SYSID_DATA_W-1:0] readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_mismatch,
  output logic                    ts_mismatch,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  localparam logic [SYSID_CNT_W-1:0] LAT = SYSID_CNT_W'(READ_LATENCY);

  sysid_state_t            r_state;
  logic [SYSID_CNT_W-1:0]  r_cnt;
  logic                    r_auto;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic                    r_id_mm;
  logic                    r_ts_mm;
  logic [SYSID_DATA_W-1:0] r_id_value;
  logic [SYSID_DATA_W-1:0] r_ts_value;

  // Strobe and address decode straight from the state register only.
  assign read    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign address = ((r_state == S_RD_TS) || (r_state == S_WT_TS)) ? SYSID_ADDR_TS
                                                                   : SYSID_ADDR_ID;

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_mismatch = r_id_mm;
  assign ts_mismatch = r_ts_mm;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_auto     <= AUTO_START;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_mm    <= 1'b0;
      r_ts_mm    <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start || r_auto) begin
            r_auto  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RD_ID;
          end
        end
        S_RD_ID: begin
          r_cnt <= LAT;
          if (LAT == SYSID_CNT_W'(0)) begin
            r_id_value <= readdata;
            r_state    <= S_RD_TS;
          end else begin
            r_state <= S_WT_ID;
          end
        end
        // Data is valid on the wait cycle where the counter reads 1.
        S_WT_ID: begin
          if (r_cnt == SYSID_CNT_W'(1)) begin
            r_id_value <= readdata;
            r_state    <= S_RD_TS;
          end else begin
            r_cnt <= r_cnt - SYSID_CNT_W'(1);
          end
        end
        S_RD_TS: begin
          r_cnt <= LAT;
          if (LAT == SYSID_CNT_W'(0)) begin
            r_ts_value <= readdata;
            r_state    <= S_CHECK;
          end else begin
            r_state <= S_WT_TS;
          end
        end
        S_WT_TS: begin
          if (r_cnt == SYSID_CNT_W'(1)) begin
            r_ts_value <= readdata;
            r_state    <= S_CHECK;
          end else begin
            r_cnt <= r_cnt - SYSID_CNT_W'(1);
          end
        end
        S_CHECK: begin
          r_id_mm <= (r_id_value != EXPECTED_ID);
          r_ts_mm <= (r_ts_value != EXPECTED_TS);
          r_pass  <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_id_mm <= 1'b0;
            r_ts_mm <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RD_ID;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that sits directly upstream of the system-ID slave and consumes its 32-bit readdata. After reset (or on request), it reads the ID word (address 0) and the timestamp word (address 1), compares them against expected parameter values, and reports pass/fail. Software and board logic use the result to detect a bitstream/software mismatch before the processor boots.

## Interface
- EXPECTED_ID, default 32'h0000_0000: required value at address 0
- EXPECTED_TS, default 32'd1476146582: required value at address 1
- READ_LATENCY, default 0: cycles from `read` assertion to valid `readdata`; 0 means same-cycle combinational data; legal range 0–7
- AUTO_START, default 1: 1 starts a check automatically on the first cycle after reset release

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that requests a check; honoured only in IDLE or DONE
- address  out  1  slave word address
- read  out  1  read strobe to the slave
- readdata  in  32  slave read data
- busy  out  1  high from check launch until DONE is entered
- done  out  1  high while in DONE
- pass  out  1  valid when done=1; 1 iff both words matched
- id_mismatch  out  1  valid when done=1
- ts_mismatch  out  1  valid when done=1
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

## Operation
- FSM states: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, CHECK, DONE.
- IDLE → RD_ID on start, or on the first post-reset cycle when AUTO_START=1.
- RD_ID drives read=1, address=0 for one cycle and loads the latency counter with READ_LATENCY.
  - If READ_LATENCY=0: capture readdata into id_value in the same cycle, then go to RD_TS.
  - Otherwise go to WT_ID.
- WT_ID: read=0, address held at 0; the counter decrements each cycle. When it reaches 1, capture readdata, then go to RD_TS.
- RD_TS and WT_TS mirror RD_ID and WT_ID with address=1, capturing into ts_value.
- CHECK, one cycle:
  - id_mismatch = (id_value != EXPECTED_ID)
  - ts_mismatch = (ts_value != EXPECTED_TS)
  - pass = neither mismatch
  - next state DONE
- DONE holds results. A start pulse in DONE clears pass, the mismatch flags and done, then enters RD_ID (re-check).
- start in any state other than IDLE or DONE is ignored; no queuing.
- Exactly one read strobe per word per check.

## Timing
- Reset values:
  - state IDLE; read=0, address=0, busy=0, done=0, pass=0
  - id_mismatch=0, ts_mismatch=0, id_value=0, ts_value=0
- All outputs are registered, except that `read` and `address` are decoded from the state register (glitch-free, no comb path from readdata).
- Check duration, from entering RD_ID to done=1: 2·(1+READ_LATENCY)+1 cycles.
  - READ_LATENCY=0: RD_ID, RD_TS, CHECK → done on cycle 4.
- busy rises the cycle after start is sampled, or the first cycle after reset when AUTO_START=1. It falls in the same cycle done rises.
- Reset asserted mid-check aborts immediately to reset values. After release, AUTO_START governs the restart.
- start in the same cycle that DONE is entered is ignored (state not yet DONE).

## Structure
- Shared package `sysid_pkg`:
  - FSM state enum
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1
  - default expected-value constants
- Latency counter: 3-bit down-counter inline; no sub-module.
- The block must be instantiated alongside the system-ID slave in the top level; the interconnect is not modified.

## Test plan
- Reset release, AUTO_START=1, slave model returning 0 at address 0 and 1476146582 at address 1, READ_LATENCY=0 → done=1 on cycle 4, pass=1, both mismatch flags 0.
- Slave timestamp returns 1476146583 → pass=0, ts_mismatch=1, id_mismatch=0, ts_value=1476146583.
- READ_LATENCY=3 with a pipelined slave model → exactly two read strobes, done on cycle 10, correct captures, read high only in RD_* states.
- AUTO_START=0: no reads until a start pulse. A start pulse while busy is ignored. A start pulse in DONE re-runs the check, and done deasserts the next cycle.
- Reset asserted in WT_TS → all outputs return to reset values asynchronously. After release, a fresh check completes with pass=1.
- Slave ID changed to 32'hDEAD_BEEF → id_mismatch=1, id_value=32'hDEAD_BEEF, pass=0.
